// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: word-addressed register bus between the system bridge and the
// interrupt controller. Bridge drives Addr/WE/Din, controller returns Dout.
interface irq_ctrl_if;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;

   modport master (
      output Addr,
      output WE,
      output Din,
      input  Dout
   );

   modport slave (
      input  Addr,
      input  WE,
      input  Din,
      output Dout
   );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source fixed-priority nesting interrupt controller.
// Ports: clk, reset (sync, active-high), bus (irq_ctrl_if.slave register
// access, Dout combinational), irq_in[5:0] raw lines, cpu_irq registered
// request to CP0. Source 0 has the highest priority.
module irq_ctrl (
   input  logic             clk,
   input  logic             reset,
   irq_ctrl_if.slave        bus,
   input  logic [5:0]       irq_in,
   output logic             cpu_irq
);

   localparam int NSRC = 6;

   localparam logic [2:0] A_MASK   = 3'd0;
   localparam logic [2:0] A_MODE   = 3'd1;
   localparam logic [2:0] A_PEND   = 3'd2;
   localparam logic [2:0] A_ISR    = 3'd3;
   localparam logic [2:0] A_VECTOR = 3'd4;
   localparam logic [2:0] A_CLAIM  = 3'd5;
   localparam logic [2:0] A_EOI    = 3'd6;
   localparam logic [2:0] A_RAW    = 3'd7;

   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] mode;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] isr;
   logic [NSRC-1:0] irq_q;

   logic [2:0]      sel;
   logic            wr_mask;
   logic            wr_mode;
   logic            wr_pend;
   logic            wr_claim;
   logic            wr_eoi;

   logic [NSRC-1:0] edge_ev;
   logic [NSRC-1:0] clr;
   logic [NSRC-1:0] cand;
   logic [7:0]      claim_oh;
   logic [NSRC-1:0] claim_vec;
   logic [NSRC-1:0] pend_nxt;
   logic [NSRC-1:0] isr_nxt;
   logic [2:0]      win;
   logic [2:0]      top;
   logic            req;

   // Index of the lowest set bit, or NSRC when the vector is empty.
   function automatic logic [2:0] low_idx(input logic [NSRC-1:0] v);
      logic [2:0] r;
      r = 3'(NSRC);
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   assign sel      = bus.Addr[4:2];
   assign wr_mask  = bus.WE && (sel == A_MASK);
   assign wr_mode  = bus.WE && (sel == A_MODE);
   assign wr_pend  = bus.WE && (sel == A_PEND);
   assign wr_claim = bus.WE && (sel == A_CLAIM);
   assign wr_eoi   = bus.WE && (sel == A_EOI);

   assign edge_ev  = irq_in & ~irq_q;
   assign cand     = pend & mask;

   // Index 6 and 7 fall off the top of the one-hot, so they never claim.
   assign claim_oh  = 8'b1 << bus.Din[2:0];
   assign claim_vec = claim_oh[NSRC-1:0] & cand & {NSRC{wr_claim}};

   // Software clears (W1C and claim) only touch edge-mode bits.
   assign clr = ((wr_pend ? bus.Din[NSRC-1:0] : '0) | claim_vec) & mode;

   always_comb begin
      pend_nxt = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (mode[k]) pend_nxt[k] = (pend[k] & ~clr[k]) | edge_ev[k];
         else         pend_nxt[k] = irq_in[k];
      end
   end

   // isr & (isr - 1) drops the lowest set bit; CLAIM and EOI never coincide.
   always_comb begin
      isr_nxt = isr | claim_vec;
      if (wr_eoi) isr_nxt = isr & (isr - 1'b1);
   end

   assign top = low_idx(isr);
   assign win = (cand != '0) ? low_idx(cand) : 3'd0;
   assign req = (cand != '0) && (win < top);

   always_ff @(posedge clk) begin
      if (reset) begin
         mask    <= '0;
         mode    <= '0;
         pend    <= '0;
         isr     <= '0;
         irq_q   <= '0;
         cpu_irq <= 1'b0;
      end else begin
         if (wr_mask) mask <= bus.Din[NSRC-1:0];
         if (wr_mode) mode <= bus.Din[NSRC-1:0];
         pend    <= pend_nxt;
         isr     <= isr_nxt;
         irq_q   <= irq_in;
         cpu_irq <= req;
      end
   end

   always_comb begin
      bus.Dout = '0;
      unique case (sel)
         A_MASK:   bus.Dout[NSRC-1:0] = mask;
         A_MODE:   bus.Dout[NSRC-1:0] = mode;
         A_PEND:   bus.Dout[NSRC-1:0] = pend;
         A_ISR:    bus.Dout[NSRC-1:0] = isr;
         A_VECTOR: bus.Dout = {cpu_irq, 28'd0, cpu_irq ? win : 3'd0};
         A_RAW:    bus.Dout[NSRC-1:0] = irq_q;
         A_CLAIM,
         A_EOI:    bus.Dout = '0;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{bus.Addr[31:5], bus.Din[31:NSRC], claim_oh[7:6]};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: vector table plus scoreboard queue for irq_ctrl, followed by
// a hand-driven pin-to-cpu_irq latency sequence.
module tb_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] irq_in;
   logic       cpu_irq;

   irq_ctrl_if bus ();

   irq_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .irq_in  (irq_in),
      .cpu_irq (cpu_irq)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] MASK = 0, MODE = 1, PEND = 2, ISR = 3;
   localparam logic [2:0] VEC = 4, CLAIM = 5, EOI = 6, RAW = 7;

   typedef struct {
      logic        rst;
      logic        we;
      logic [2:0]  a;
      logic [31:0] din;
      logic [5:0]  irq;
      logic [2:0]  ca;
      logic [31:0] ed;
      logic        ei;
   } vec_t;

   typedef struct {
      logic [2:0]  ca;
      logic [31:0] ed;
      logic        ei;
      int          idx;
   } exp_t;

   vec_t tv[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic v(input logic rst, input logic we, input logic [2:0] a,
                    input logic [31:0] din, input logic [5:0] irq,
                    input logic [2:0] ca, input logic [31:0] ed,
                    input logic ei);
      vec_t t;
      t.rst = rst; t.we = we; t.a = a; t.din = din; t.irq = irq;
      t.ca = ca; t.ed = ed; t.ei = ei;
      tv.push_back(t);
   endtask

   task automatic nop(input logic [5:0] irq, input logic [2:0] ca,
                      input logic [31:0] ed, input logic ei);
      v(1'b0, 1'b0, MASK, 32'd0, irq, ca, ed, ei);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] din,
                     input logic [5:0] irq, input logic [2:0] ca,
                     input logic [31:0] ed, input logic ei);
      v(1'b0, 1'b1, a, din, irq, ca, ed, ei);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   lat;
      reset = 1'b1; irq_in = '0;
      bus.Addr = '0; bus.WE = 1'b0; bus.Din = '0;

      // reset, overriding a concurrent write
      v(1, 0, MASK, 0,     6'h3F, PEND, 0, 0);
      v(1, 1, MASK, 6'h3F, 6'h3F, MASK, 0, 0);
      v(1, 0, MASK, 0,     6'h3F, ISR,  0, 0);
      nop(6'h3F, PEND, 6'h3F, 0);
      nop(6'h3F, RAW,  6'h3F, 0);
      nop(6'h00, PEND, 0, 0);
      // level path
      wr(MASK, 1, 0, MASK, 1, 0);
      nop(1, PEND, 1, 0);
      nop(1, VEC, 32'h8000_0000, 1);
      wr(CLAIM, 0, 1, ISR, 1, 1);
      nop(1, ISR, 1, 0);
      nop(0, PEND, 0, 0);
      wr(EOI, 0, 0, ISR, 0, 0);
      nop(0, VEC, 0, 0);
      // edge latch and W1C
      wr(MODE, 4, 0, MODE, 4, 0);
      wr(MASK, 4, 0, MASK, 4, 0);
      nop(4, PEND, 4, 0);
      nop(0, PEND, 4, 1);
      nop(0, VEC, 32'h8000_0002, 1);
      wr(PEND, 4, 0, PEND, 0, 1);
      nop(0, PEND, 0, 0);
      // pulse coincident with W1C: set wins
      wr(PEND, 4, 4, PEND, 4, 0);
      nop(0, PEND, 4, 1);
      wr(CLAIM, 2, 0, ISR, 4, 1);
      nop(0, PEND, 0, 0);
      wr(EOI, 0, 0, ISR, 0, 0);
      // pulse coincident with CLAIM: ISR set, PEND kept
      nop(4, PEND, 4, 0);
      nop(0, PEND, 4, 1);
      wr(CLAIM, 2, 4, PEND, 4, 1);
      nop(0, ISR, 4, 0);
      wr(PEND, 4, 0, PEND, 0, 0);
      wr(EOI, 0, 0, ISR, 0, 0);
      // ignored writes
      wr(CLAIM, 7, 0, ISR, 0, 0);
      nop(8, PEND, 8, 0);
      wr(CLAIM, 3, 8, ISR, 0, 0);
      wr(EOI, 0, 8, ISR, 0, 0);
      wr(ISR, 6'h3F, 8, ISR, 0, 0);
      wr(VEC, 6'h3F, 8, PEND, 8, 0);
      nop(0, PEND, 0, 0);
      // nesting
      wr(MASK, 3, 0, MASK, 3, 0);
      nop(2, PEND, 2, 0);
      nop(2, VEC, 32'h8000_0001, 1);
      wr(CLAIM, 1, 2, ISR, 2, 1);
      nop(2, ISR, 2, 0);
      nop(3, PEND, 3, 0);
      nop(3, VEC, 32'h8000_0000, 1);
      wr(CLAIM, 0, 3, ISR, 3, 1);
      nop(3, ISR, 3, 0);
      wr(EOI, 0, 2, ISR, 2, 0);
      nop(2, ISR, 2, 0);
      wr(EOI, 0, 2, ISR, 0, 0);
      nop(2, VEC, 32'h8000_0001, 1);
      nop(0, PEND, 0, 1);
      nop(0, ISR, 0, 0);
      // lower priority held off while source 0 in service
      nop(1, PEND, 1, 0);
      wr(CLAIM, 0, 1, ISR, 1, 1);
      nop(2, PEND, 2, 0);
      nop(2, VEC, 0, 0);
      wr(EOI, 0, 2, ISR, 0, 0);
      nop(2, VEC, 32'h8000_0001, 1);
      // mode changes
      wr(MODE, 6, 2, PEND, 2, 1);
      nop(0, PEND, 2, 1);
      wr(MODE, 4, 0, PEND, 2, 1);
      nop(0, PEND, 0, 1);
      nop(0, PEND, 0, 0);
      // clearing MASK keeps ISR
      nop(2, PEND, 2, 0);
      wr(CLAIM, 1, 2, ISR, 2, 1);
      wr(MASK, 0, 2, ISR, 2, 0);
      wr(EOI, 0, 0, ISR, 0, 0);

      foreach (tv[i]) begin
         @(negedge clk);
         reset    = tv[i].rst;
         bus.WE   = tv[i].we;
         bus.Addr = {27'd0, tv[i].a};
         bus.Din  = tv[i].din;
         irq_in   = tv[i].irq;
         e.ca = tv[i].ca; e.ed = tv[i].ed; e.ei = tv[i].ei; e.idx = i;
         sb.push_back(e);
         @(posedge clk);
         #1;
         bus.WE = 1'b0;
         e = sb.pop_front();
         bus.Addr = {27'd0, e.ca};
         #1;
         n_vec++;
         if (bus.Dout !== e.ed || cpu_irq !== e.ei) begin
            n_err++;
            $display("FAIL vec%0d reg%0d: got Dout=%h irq=%b, need Dout=%h irq=%b",
                     e.idx, e.ca, bus.Dout, cpu_irq, e.ed, e.ei);
         end
      end

      // pin-to-cpu_irq latency on source 0, level mode
      @(negedge clk);
      reset = 1'b0; bus.WE = 1'b1; bus.Addr = {27'd0, MASK}; bus.Din = 1;
      irq_in = 0;
      @(negedge clk);
      bus.WE = 1'b0; bus.Addr = {27'd0, VEC}; irq_in = 6'h01;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (cpu_irq === 1'b1) begin
            lat = c;
            break;
         end
      end
      n_vec++;
      if (lat != 2) begin
         n_err++;
         $display("FAIL latency: got %0d cycles (0=timeout), need 2", lat);
      end
      n_vec++;
      if (bus.Dout !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL latency_vec: got %h, need 80000000", bus.Dout);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
